// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: keeps at most one memory read in flight and queues
// returned words in a small FIFO for decode; redirect flushes and restarts.
module ifetch_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ADDR_WIDTH-1:0]         imem_addr_o,
    output logic                          imem_read_o,
    input  logic [DATA_WIDTH-1:0]         imem_rdata_i,
    input  logic                          imem_ready_i,
    output logic                          fetch_valid_o,
    output logic [DATA_WIDTH-1:0]         fetch_instr_o,
    output logic [ADDR_WIDTH-1:0]         fetch_pc_o,
    input  logic                          fetch_ready_i,
    input  logic                          redirect_i,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
    output logic [$clog2(DEPTH+1)-1:0]    buf_count_o,
    output logic [1:0]                    dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [ADDR_WIDTH-1:0]   held_addr;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_next;
    logic [ADDR_WIDTH-1:0]   pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0]   instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   redirect_target;
    logic                    push;
    logic                    pop;
    logic                    buf_nonempty;

    // Both handshakes transfer on the cycle where valid (imem_read_o /
    // fetch_valid_o) and ready (imem_ready_i / fetch_ready_i) are both high;
    // valid, once raised, holds its address/payload stable until that cycle.
    assign redirect_target = redirect_pc_i & ~ADDR_WIDTH'(3);
    assign buf_nonempty    = (count != '0);
    assign push            = (state == REQ) & imem_ready_i & ~redirect_i;
    assign fetch_valid_o   = buf_nonempty & ~redirect_i;
    assign pop             = fetch_valid_o & fetch_ready_i;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    assign imem_read_o   = (state != IDLE);
    // DISCARD keeps the abandoned address on the bus until memory answers.
    assign imem_addr_o   = (state == DISCARD) ? held_addr : fetch_pc;
    assign fetch_instr_o = buf_nonempty ? instr_mem[rd_ptr] : '0;
    assign fetch_pc_o    = buf_nonempty ? pc_mem[rd_ptr] : '0;
    assign buf_count_o   = count;
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            held_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (redirect_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end

            case (state)
                IDLE: begin
                    if (redirect_i)
                        fetch_pc <= redirect_target;
                    else if (count < CW'(DEPTH))
                        state <= REQ;
                end
                REQ: begin
                    if (redirect_i) begin
                        fetch_pc <= redirect_target;
                        if (imem_ready_i) begin
                            state <= IDLE;
                        end else begin
                            held_addr <= fetch_pc;
                            state     <= DISCARD;
                        end
                    end else if (imem_ready_i) begin
                        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                        if (count_next >= CW'(DEPTH))
                            state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect_i)
                        fetch_pc <= redirect_target;
                    if (imem_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: stimulus queues expected fetches, a
// negedge monitor pops and compares every accepted decode transfer.
module tb_ifetch_prefetch;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] imem_addr_o;
    logic          imem_read_o;
    logic [DW-1:0] imem_rdata_i;
    logic          imem_ready_i;
    logic          fetch_valid_o;
    logic [DW-1:0] fetch_instr_o;
    logic [AW-1:0] fetch_pc_o;
    logic          fetch_ready_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic [CW-1:0] buf_count_o;
    logic [1:0]    dbg_state;

    logic [63:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    ifetch_prefetch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr_o  (imem_addr_o),
        .imem_read_o  (imem_read_o),
        .imem_rdata_i (imem_rdata_i),
        .imem_ready_i (imem_ready_i),
        .fetch_valid_o(fetch_valid_o),
        .fetch_instr_o(fetch_instr_o),
        .fetch_pc_o   (fetch_pc_o),
        .fetch_ready_i(fetch_ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .buf_count_o  (buf_count_o),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    always @(negedge clk) begin
        if (!rst && fetch_valid_o && fetch_ready_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL fetch_unexpected: got pc %0h, want no transfer", fetch_pc_o);
            end else begin
                check("fetch_pc_instr", {fetch_pc_o, fetch_instr_o}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        imem_ready_i  = 1'b0;
        fetch_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        step();
        step();

        check("rst_read",  imem_read_o,   0);
        check("rst_addr",  imem_addr_o,   0);
        check("rst_valid", fetch_valid_o, 0);
        check("rst_instr", fetch_instr_o, 0);
        check("rst_pc",    fetch_pc_o,    0);
        check("rst_count", buf_count_o,   0);
        check("rst_state", dbg_state,     0);

        // Fill from reset with memory always ready and decode stalled.
        imem_ready_i = 1'b1;
        rst          = 1'b0;
        step();
        check("first_state", dbg_state, 1);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", imem_addr_o, 64'(i * 4));
            check("fill_read", imem_read_o, 1);
            expect_fetch(32'(i * 4));
            step();
        end
        check("full_read",  imem_read_o,   0);
        check("full_count", buf_count_o,   4);
        check("full_valid", fetch_valid_o, 1);
        check("full_state", dbg_state,     0);
        step();
        check("full_hold_read", imem_read_o, 0);

        // Single pop from a full buffer, then refill one entry.
        fetch_ready_i = 1'b1;
        step();
        fetch_ready_i = 1'b0;
        check("pop_count", buf_count_o, 3);
        check("pop_read",  imem_read_o, 0);
        step();
        check("refill_addr", imem_addr_o, 32'h10);
        check("refill_read", imem_read_o, 1);
        expect_fetch(32'h10);
        step();
        check("refill_count", buf_count_o, 4);
        check("refill_read2", imem_read_o, 0);

        // Drain with memory stalled: request to 0x14 left hanging.
        imem_ready_i  = 1'b0;
        fetch_ready_i = 1'b1;
        repeat (4) step();
        fetch_ready_i = 1'b0;
        check("drain_count", buf_count_o, 0);
        check("drain_state", dbg_state,   1);
        check("drain_addr",  imem_addr_o, 32'h14);

        // Redirect with the request outstanding: drain, then restart at 0x100.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        step();
        redirect_i = 1'b0;
        check("disc_state", dbg_state,   2);
        check("disc_addr",  imem_addr_o, 32'h14);
        check("disc_read",  imem_read_o, 1);
        step();
        check("disc_hold_addr", imem_addr_o, 32'h14);
        imem_ready_i = 1'b1;
        step();
        imem_ready_i = 1'b0;
        check("disc_done_state", dbg_state,   0);
        check("disc_done_count", buf_count_o, 0);
        step();
        check("redir_state", dbg_state,   1);
        check("redir_addr",  imem_addr_o, 32'h100);
        imem_ready_i = 1'b1;
        step();
        expect_fetch(32'h100);
        check("redir_count", buf_count_o,   1);
        check("redir_next",  imem_addr_o,   32'h104);
        check("redir_valid", fetch_valid_o, 1);

        // Redirect in the same cycle as ready: data dropped, buffer flushed.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        exp_q.delete();
        #1;
        check("redir_valid_mask", fetch_valid_o, 0);
        step();
        redirect_i = 1'b0;
        check("same_count", buf_count_o, 0);
        check("same_state", dbg_state,   0);
        step();
        check("same_addr", imem_addr_o, 32'h200);
        step(); expect_fetch(32'h200);
        step(); expect_fetch(32'h204);
        step(); expect_fetch(32'h208);
        check("three_count", buf_count_o, 3);

        // Push and pop together at DEPTH-1, streaming one per cycle.
        fetch_ready_i = 1'b1;
        step(); expect_fetch(32'h20C);
        check("pushpop_count", buf_count_o, 3);
        check("pushpop_read",  imem_read_o, 1);
        step(); expect_fetch(32'h210);
        step(); expect_fetch(32'h214);
        check("stream_count", buf_count_o, 3);

        // Redirect to the top of the address space (low bits ignored).
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        exp_q.delete();
        step();
        redirect_i = 1'b0;
        check("wrap_flush_count", buf_count_o, 0);
        step();
        check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        step(); expect_fetch(32'hFFFF_FFFC);
        check("wrap_addr1", imem_addr_o, 32'h0);
        step(); expect_fetch(32'h0);
        fetch_ready_i = 1'b0;
        check("wrap_addr2", imem_addr_o, 32'h4);
        step(); expect_fetch(32'h4);
        imem_ready_i = 1'b0;
        check("pre_rst_count", buf_count_o, 2);
        check("pre_rst_read",  imem_read_o, 1);

        // Asynchronous reset mid-request.
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("arst_read",  imem_read_o,   0);
        check("arst_count", buf_count_o,   0);
        check("arst_valid", fetch_valid_o, 0);
        check("arst_addr",  imem_addr_o,   0);
        step();
        rst = 1'b0;
        step();
        check("leftover", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_prefetch.md
IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the PC and instruction-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter DEPTH, default 4, SHALL set prefetch-buffer entries; it SHALL be a power of two, >=2.
REQ-004 Parameter RESET_PC, default 0, SHALL set the first fetch address; its bits [1:0] SHALL be 0.
REQ-005 Port clk, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: SHALL be an asynchronous, active-high reset.
REQ-007 Port imem_addr_o, output, ADDR_WIDTH: SHALL carry the instruction-memory read address.
REQ-008 Port imem_read_o, output, 1: SHALL carry the read request, held high until accepted.
REQ-009 Port imem_rdata_i, input, DATA_WIDTH: SHALL carry read data, valid when imem_ready_i=1.
REQ-010 Port imem_ready_i, input, 1: SHALL indicate request completion and valid data this cycle.
REQ-011 Port fetch_valid_o, output, 1: SHALL indicate a buffered instruction is offered to decode.
REQ-012 Port fetch_instr_o, output, DATA_WIDTH: SHALL carry the buffer-head instruction.
REQ-013 Port fetch_pc_o, output, ADDR_WIDTH: SHALL carry the buffer-head instruction address.
REQ-014 Port fetch_ready_i, input, 1: SHALL indicate decode accepts the head; pop when valid&ready.
REQ-015 Port redirect_i, input, 1: SHALL request a flush and restart of fetch.
REQ-016 Port redirect_pc_i, input, ADDR_WIDTH: SHALL carry the new target; bits [1:0] are ignored and treated as 0.
REQ-017 Port buf_count_o, output, $clog2(DEPTH+1): SHALL carry the current buffer occupancy.

Function
REQ-018 The FSM SHALL have three states: IDLE (imem_read_o=0), REQ and DISCARD (both imem_read_o=1).
REQ-019 IDLE SHALL go to REQ when occupancy < DEPTH and redirect_i=0.
REQ-020 In REQ, imem_addr_o SHALL equal the fetch PC, held stable until imem_ready_i=1.
REQ-021 REQ with imem_ready_i=1 and redirect_i=0 SHALL push {fetch PC, imem_rdata_i} and advance the fetch PC by 4 modulo 2^ADDR_WIDTH.
REQ-022 After a push, the FSM SHALL stay in REQ if next-cycle occupancy < DEPTH; otherwise it SHALL go to IDLE.
REQ-023 The block SHALL keep at most one memory request outstanding and SHALL never push into a full buffer.
REQ-024 REQ with redirect_i=1 and imem_ready_i=0 SHALL go to DISCARD, load the fetch PC with redirect_pc_i and keep imem_addr_o at the old address.
REQ-025 REQ with redirect_i=1 and imem_ready_i=1 SHALL drop the returned data, load redirect_pc_i and go to IDLE.
REQ-026 DISCARD SHALL hold the request; on imem_ready_i=1 it SHALL drop the data and go to IDLE.
REQ-027 redirect_i in DISCARD or IDLE SHALL overwrite the pending target PC; in DISCARD the drain SHALL continue.
REQ-028 redirect_i SHALL empty the buffer so that occupancy is 0 next cycle, regardless of state.
REQ-029 fetch_valid_o SHALL equal (occupancy != 0) & ~redirect_i; no pop SHALL occur in a redirect cycle.
REQ-030 Simultaneous push and pop SHALL leave occupancy unchanged, including at occupancy DEPTH-1.
REQ-031 Pushed data SHALL become visible on fetch_* the cycle after the accepting edge; with ready tied high, throughput SHALL be one instruction per cycle.
REQ-032 Buffer read and write pointers SHALL wrap modulo DEPTH; the buffer SHALL preserve FIFO order.

Reset
REQ-033 While rst=1, the block SHALL hold: state IDLE, fetch PC RESET_PC, occupancy 0, imem_read_o=0, imem_addr_o=RESET_PC, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_o=0, buf_count_o=0.
REQ-034 rst asserted mid-request SHALL abandon the request immediately without draining it.
REQ-035 On the first edge after rst deasserts, the FSM SHALL enter REQ.

Verification
REQ-036 Reset release with imem_ready_i=1 and fetch_ready_i=0, DEPTH=4: expect addresses 0x0, 0x4, 0x8, 0xC, then imem_read_o=0 and buf_count_o=4.
REQ-037 Full buffer, fetch_ready_i=1 for one cycle: expect head pc 0x0 popped, a new request to 0x10, and occupancy returning to 4.
REQ-038 imem_ready_i=0 in REQ at 0x8, redirect_i=1 to 0x103: expect DISCARD, imem_addr_o=0x8 held, data dropped on ready, next request to 0x100, occupancy 0.
REQ-039 redirect_i and imem_ready_i in the same cycle at 0x4, target 0x200: expect no push, occupancy 0, next request to 0x200.
REQ-040 PC 0xFFFFFFFC with 32-bit addresses: expect the next request to 0x0 and fetch_pc_o order 0xFFFFFFFC then 0x0.
REQ-041 rst asserted while imem_read_o=1 with occupancy 2: expect imem_read_o=0, buf_count_o=0, fetch_valid_o=0 immediately.
